// File: rtl/ads_touch_spi_if.sv
// Avalon-MM register port of the touch SPI master: CPU side drives master, block is slave.
interface ads_touch_spi_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata, input readdata, irq);
  modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/ads_touch_spi.sv
// ADS7843 SPI master: pen-down or CTRL start runs an X then Y 24-clock frame; results and drdy/irq on Avalon.
// Triggers while busy are dropped; readdata is registered one cycle after address, no wait states.
module ads_touch_spi #(
  parameter int         CLK_DIV = 25,
  parameter logic [7:0] X_CMD   = 8'hD0,
  parameter logic [7:0] Y_CMD   = 8'h90
) (
  input  logic           clk,
  input  logic           reset,
  ads_touch_spi_if.slave bus,
  input  logic           ads_nirq,
  input  logic           ads_dout,
  output logic           ads_din,
  output logic           ads_dclk,
  output logic           ads_cs_n
);
  localparam int            CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_FRAME_X, S_FRAME_Y, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_bit;
  logic [7:0]    r_cmd;
  logic [11:0]   r_shift;
  logic [11:0]   r_stage;
  logic [11:0]   r_x;
  logic [11:0]   r_y;
  logic          r_dclk;
  logic          r_cs_n;
  logic          r_din;
  logic          r_nirq_d1;
  logic          r_nirq_d2;
  logic          r_pen_edge;
  logic          r_auto_en;
  logic          r_irq_en;
  logic          r_drdy;
  logic [31:0]   r_readdata;

  logic w_wr;
  logic w_start;
  logic w_trigger;
  logic w_half_end;
  logic w_frame_end;
  logic w_done_set;
  logic w_busy;
  logic w_unused;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_start     = w_wr && (bus.address == 2'd0) && bus.writedata[1];
  assign w_trigger   = w_start | r_pen_edge;
  assign w_half_end  = (r_cnt == CNT_MAX);
  assign w_frame_end = w_half_end && r_dclk && (r_bit == 5'd23);
  assign w_busy      = (r_state != S_IDLE);
  // Holding the set through the DONE cycle makes a coincident W1C lose.
  assign w_done_set  = (r_state == S_DONE) || ((r_state == S_FRAME_Y) && w_frame_end);
  assign w_unused    = &{1'b0, bus.writedata[31:3]};

  assign ads_din      = r_din;
  assign ads_dclk     = r_dclk;
  assign ads_cs_n     = r_cs_n;
  assign bus.readdata = r_readdata;
  assign bus.irq      = r_drdy & r_irq_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_cmd   <= '0;
      r_shift <= '0;
      r_stage <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_dclk  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_din   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_state <= S_SETUP;
            r_cs_n  <= 1'b0;
            r_cnt   <= '0;
          end
        end
        S_SETUP: begin
          if (w_half_end) begin
            r_state <= S_FRAME_X;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_cmd   <= X_CMD;
            r_din   <= X_CMD[7];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FRAME_X, S_FRAME_Y: begin
          if (!w_half_end) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (!r_dclk) begin
              r_dclk <= 1'b1;
              // Periods 10..21 carry D11..D0.
              if (r_bit >= 5'd9 && r_bit <= 5'd20) r_shift <= {r_shift[10:0], ads_dout};
            end else begin
              r_dclk <= 1'b0;
              if (r_bit != 5'd23) begin
                r_bit <= r_bit + 5'd1;
                r_cmd <= {r_cmd[6:0], 1'b0};
                r_din <= r_cmd[6];
              end else if (r_state == S_FRAME_X) begin
                r_state <= S_FRAME_Y;
                r_bit   <= '0;
                r_stage <= r_shift;
                r_cmd   <= Y_CMD;
                r_din   <= Y_CMD[7];
              end else begin
                r_state <= S_DONE;
                r_x     <= r_stage;
                r_y     <= r_shift;
                r_cs_n  <= 1'b1;
                r_din   <= 1'b0;
              end
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_nirq_d1  <= 1'b1;
      r_nirq_d2  <= 1'b1;
      r_pen_edge <= 1'b0;
      r_auto_en  <= 1'b0;
      r_irq_en   <= 1'b0;
      r_drdy     <= 1'b0;
      r_readdata <= '0;
    end else begin
      r_nirq_d1  <= ads_nirq;
      r_nirq_d2  <= r_nirq_d1;
      r_pen_edge <= ~r_nirq_d1 & r_nirq_d2 & r_auto_en;
      if (w_wr && bus.address == 2'd0) r_auto_en <= bus.writedata[2];
      if (w_wr && bus.address == 2'd3) r_irq_en  <= bus.writedata[1];
      if (w_done_set) r_drdy <= 1'b1;
      else if (w_wr && bus.address == 2'd3 && bus.writedata[0]) r_drdy <= 1'b0;
      case (bus.address)
        2'd0: r_readdata <= {29'd0, r_auto_en, 1'b0, w_busy};
        2'd1: r_readdata <= {20'd0, r_x};
        2'd2: r_readdata <= {20'd0, r_y};
        2'd3: r_readdata <= {30'd0, r_irq_en, r_drdy};
      endcase
    end
  end
endmodule

// File: tb/tb_ads_touch_spi.sv
// Directed bench: default-divider instance for the main scenarios, CLK_DIV=2 instance for the fast-clock case.
module tb_ads_touch_spi;
  timeunit 1ns;
  timeprecision 1ps;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic ads_nirq = 1'b1;
  logic ads_din, ads_dclk, ads_cs_n;
  logic ads_din2, ads_dclk2, ads_cs_n2;
  logic m1_dout = 1'b0;
  logic m2_dout = 1'b0;
  int checks = 0;
  int errors = 0;

  ads_touch_spi_if bus1 ();
  ads_touch_spi_if bus2 ();

  ads_touch_spi u_dut (
    .clk(clk), .reset(reset), .bus(bus1), .ads_nirq(ads_nirq), .ads_dout(m1_dout),
    .ads_din(ads_din), .ads_dclk(ads_dclk), .ads_cs_n(ads_cs_n));

  ads_touch_spi #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2), .ads_nirq(1'b1), .ads_dout(m2_dout),
    .ads_din(ads_din2), .ads_dclk(ads_dclk2), .ads_cs_n(ads_cs_n2));

  always #5 clk = ~clk;

  // Controller models: return a programmed X/Y pair, capture command bytes.
  function automatic logic model_bit(input logic [11:0] x, input logic [11:0] y, input int p);
    int q;
    logic [11:0] d;
    q = (p - 1) % 24 + 1;
    d = (p <= 24) ? x : y;
    if (q >= 10 && q <= 21) return d[21 - q];
    return 1'b0;
  endfunction

  logic [11:0] m1_x = '0, m1_y = '0, m2_x = '0, m2_y = '0;
  logic [7:0]  m1_cx, m1_cy, m2_cx, m2_cy;
  int m1_n = 0, m1_rises = 0, m1_csf = 0, m1_hi = 0;
  int m2_n = 0, m2_rises = 0;
  time m1_thi = 0, m2_last = 0, m2_per = 0;

  always @(negedge ads_cs_n or posedge ads_dclk) begin
    if (ads_dclk) begin
      m1_n++;
      m1_rises++;
      if (m1_n <= 8) m1_cx = {m1_cx[6:0], ads_din};
      else if (m1_n >= 25 && m1_n <= 32) m1_cy = {m1_cy[6:0], ads_din};
    end else begin
      m1_n = 0;
      m1_csf++;
    end
  end
  always @(negedge ads_dclk) m1_dout = model_bit(m1_x, m1_y, m1_n + 1);
  always @(posedge ads_cs_n or negedge ads_cs_n) begin
    if (ads_cs_n) m1_thi = $time;
    else m1_hi = int'(($time - m1_thi) / 10);
  end

  always @(negedge ads_cs_n2 or posedge ads_dclk2) begin
    if (ads_dclk2) begin
      m2_n++;
      m2_rises++;
      m2_per = $time - m2_last;
      m2_last = $time;
      if (m2_n <= 8) m2_cx = {m2_cx[6:0], ads_din2};
      else if (m2_n >= 25 && m2_n <= 32) m2_cy = {m2_cy[6:0], ads_din2};
    end else begin
      m2_n = 0;
    end
  end
  always @(negedge ads_dclk2) m2_dout = model_bit(m2_x, m2_y, m2_n + 1);

  // Bus tasks assume they are called just after a rising edge.
  task automatic wr(input bit sel2, input logic [1:0] a, input logic [31:0] d);
    if (sel2) begin
      bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b0; bus2.writedata = d;
    end else begin
      bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b0; bus1.writedata = d;
    end
    @(posedge clk); #1;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1;
    bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
  endtask

  task automatic rd(input bit sel2, input logic [1:0] a, output logic [31:0] d);
    if (sel2) begin bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b1; end
    else begin bus1.address = a; bus1.chipselect = 1'b1; bus1.write_n = 1'b1; end
    @(posedge clk); #1;
    d = sel2 ? bus2.readdata : bus1.readdata;
    bus1.chipselect = 1'b0; bus2.chipselect = 1'b0;
  endtask

  task automatic wait_irq(input int limit, output int n, output bit ok);
    n = 0;
    while (n < limit && !bus1.irq) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus1.irq;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int n;
    #2 reset = 1'b1;
    #20;
    checks++; if (ads_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b exp 1", ads_cs_n); end
    checks++; if (ads_dclk !== 1'b0 || ads_din !== 1'b0) begin errors++; $display("FAIL rst_dclk_din: got %b%b exp 00", ads_dclk, ads_din); end
    checks++; if (bus1.readdata !== 32'd0 || bus1.irq !== 1'b0) begin errors++; $display("FAIL rst_bus: got rd=%h irq=%b exp 0 0", bus1.readdata, bus1.irq); end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    wr(1'b0, 2'd0, 32'h2);
    n = 0;
    while (n < 200 && ads_dclk !== 1'b1) begin @(posedge clk); #1; n++; end
    checks++; if (ads_cs_n !== 1'b0 || ads_dclk !== 1'b1) begin errors++; $display("FAIL midx_active: got cs_n=%b dclk=%b exp 0 1", ads_cs_n, ads_dclk); end
    #3 reset = 1'b1;
    #1;
    checks++; if (ads_cs_n !== 1'b1 || ads_dclk !== 1'b0) begin errors++; $display("FAIL midx_async_rst: got cs_n=%b dclk=%b exp 1 0", ads_cs_n, ads_dclk); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(1'b0, 2'd0, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_rst_ctrl: got %h exp 0", d); end
    rd(1'b0, 2'd1, d);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL post_rst_x: got %h exp 0", d); end
    rd(1'b0, 2'd2, d);
    checks++; if (d !== 32'd0 || bus1.irq !== 1'b0) begin errors++; $display("FAIL post_rst_y_irq: got %h irq=%b exp 0 0", d, bus1.irq); end
  endtask

  task automatic test_auto();
    logic [31:0] d;
    int n;
    bit ok;
    m1_x = 12'hA5C; m1_y = 12'h3F1;
    wr(1'b0, 2'd3, 32'h2);
    wr(1'b0, 2'd0, 32'h4);
    repeat (3) @(posedge clk);
    #1 ads_nirq = 1'b0;
    wait_irq(3000, n, ok);
    checks++; if (!ok || n != 2428) begin errors++; $display("FAIL auto_irq_latency: got %0d cycles (irq=%b) exp 2428", n, ok); end
    checks++; if (ads_cs_n !== 1'b1) begin errors++; $display("FAIL auto_cs_done: got %b exp 1", ads_cs_n); end
    ads_nirq = 1'b1;
    checks++; if (m1_cx !== 8'hD0 || m1_cy !== 8'h90) begin errors++; $display("FAIL auto_cmds: got %h %h exp d0 90", m1_cx, m1_cy); end
    rd(1'b0, 2'd1, d);
    checks++; if (d !== 32'hA5C) begin errors++; $display("FAIL auto_x: got %h exp a5c", d); end
    rd(1'b0, 2'd2, d);
    checks++; if (d !== 32'h3F1) begin errors++; $display("FAIL auto_y: got %h exp 3f1", d); end
    rd(1'b0, 2'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL auto_irqreg: got %h exp 3", d); end
    wr(1'b0, 2'd3, 32'h3);
    checks++; if (bus1.irq !== 1'b0) begin errors++; $display("FAIL auto_w1c: got irq=%b exp 0", bus1.irq); end
  endtask

  task automatic test_manual();
    logic [31:0] d;
    int c0, bad, n;
    bit ok;
    wr(1'b0, 2'd0, 32'h0);
    c0 = m1_csf;
    ads_nirq = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    checks++; if (m1_csf != c0 || ads_cs_n !== 1'b1) begin errors++; $display("FAIL noauto_no_txn: got csf=%0d cs_n=%b exp %0d 1", m1_csf, ads_cs_n, c0); end
    ads_nirq = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    m1_x = 12'h801; m1_y = 12'h7FE;
    wr(1'b0, 2'd0, 32'h2);
    checks++; if (ads_cs_n !== 1'b0) begin errors++; $display("FAIL start_cs_latency: got %b exp 0", ads_cs_n); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      repeat (100) @(posedge clk);
      #1;
      rd(1'b0, 2'd0, d);
      if (d !== 32'h1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL busy_readable: got %0d bad reads exp 0", bad); end
    wait_irq(1000, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL manual_done: got irq=0 after %0d cycles exp 1", n); end
    repeat (2) @(posedge clk);
    #1;
    rd(1'b0, 2'd0, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL manual_idle_ctrl: got %h exp 0", d); end
    rd(1'b0, 2'd1, d);
    checks++; if (d !== 32'h801) begin errors++; $display("FAIL manual_x: got %h exp 801", d); end
    rd(1'b0, 2'd2, d);
    checks++; if (d !== 32'h7FE) begin errors++; $display("FAIL manual_y: got %h exp 7fe", d); end
  endtask

  task automatic test_back_to_back();
    int r0, c0, n;
    bit ok;
    wr(1'b0, 2'd3, 32'h3);
    wr(1'b0, 2'd0, 32'h4);
    r0 = m1_rises; c0 = m1_csf;
    wr(1'b0, 2'd0, 32'h6);
    repeat (500) @(posedge clk);
    #1;
    wr(1'b0, 2'd0, 32'h6);
    ads_nirq = 1'b0;
    repeat (300) @(posedge clk);
    #1 ads_nirq = 1'b1;
    wait_irq(3000, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_done: got irq=0 after %0d cycles exp 1", n); end
    checks++; if (m1_rises - r0 != 48 || m1_csf - c0 != 1) begin errors++; $display("FAIL b2b_one_burst: got rises=%0d bursts=%0d exp 48 1", m1_rises - r0, m1_csf - c0); end
    m1_x = 12'h0F0; m1_y = 12'hF0F;
    wr(1'b0, 2'd0, 32'h2);
    wr(1'b0, 2'd0, 32'h2);
    wr(1'b0, 2'd0, 32'h2);
    checks++; if (ads_cs_n !== 1'b0 || m1_hi < 2) begin errors++; $display("FAIL b2b_cs_high: got cs_n=%b high=%0d cycles exp 0 >=2", ads_cs_n, m1_hi); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    int n;
    bit ok;
    wr(1'b0, 2'd3, 32'h3);
    checks++; if (bus1.irq !== 1'b0) begin errors++; $display("FAIL w1c_pre_clear: got irq=%b exp 0", bus1.irq); end
    wait_irq(3000, n, ok);
    checks++; if (!ok) begin errors++; $display("FAIL w1c_done: got irq=0 after %0d cycles exp 1", n); end
    wr(1'b0, 2'd3, 32'h3);
    checks++; if (bus1.irq !== 1'b1) begin errors++; $display("FAIL w1c_set_wins: got irq=%b exp 1", bus1.irq); end
    rd(1'b0, 2'd3, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL w1c_set_wins_reg: got %h exp 3", d); end
    rd(1'b0, 2'd1, d);
    checks++; if (d !== 32'h0F0) begin errors++; $display("FAIL w1c_x: got %h exp 0f0", d); end
    rd(1'b0, 2'd2, d);
    checks++; if (d !== 32'hF0F) begin errors++; $display("FAIL w1c_y: got %h exp f0f", d); end
    wr(1'b0, 2'd3, 32'h3);
    checks++; if (bus1.irq !== 1'b0) begin errors++; $display("FAIL w1c_later_clear: got irq=%b exp 0", bus1.irq); end
    rd(1'b0, 2'd3, d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL w1c_later_reg: got %h exp 2", d); end
  endtask

  task automatic test_clkdiv2();
    logic [11:0] xs [2];
    logic [11:0] ys [2];
    logic [31:0] d;
    int n, r0;
    xs[0] = 12'hFFF; ys[0] = 12'h000;
    xs[1] = 12'h000; ys[1] = 12'hFFF;
    for (int k = 0; k < 2; k++) begin
      m2_x = xs[k]; m2_y = ys[k];
      r0 = m2_rises;
      wr(1'b1, 2'd0, 32'h2);
      checks++; if (ads_cs_n2 !== 1'b0) begin errors++; $display("FAIL div2_start[%0d]: got cs_n=%b exp 0", k, ads_cs_n2); end
      n = 0;
      while (n < 1000 && ads_cs_n2 !== 1'b1) begin @(posedge clk); #1; n++; end
      checks++; if (n != 194) begin errors++; $display("FAIL div2_cs_to_done[%0d]: got %0d cycles exp 194", k, n); end
      checks++; if (m2_per != 40 || m2_rises - r0 != 48) begin errors++; $display("FAIL div2_dclk[%0d]: got period=%0t rises=%0d exp 40 48", k, m2_per, m2_rises - r0); end
      checks++; if (m2_cx !== 8'hD0 || m2_cy !== 8'h90) begin errors++; $display("FAIL div2_cmds[%0d]: got %h %h exp d0 90", k, m2_cx, m2_cy); end
      repeat (2) @(posedge clk);
      #1;
      rd(1'b1, 2'd1, d);
      checks++; if (d[11:0] !== xs[k]) begin errors++; $display("FAIL div2_x[%0d]: got %h exp %h", k, d, xs[k]); end
      rd(1'b1, 2'd2, d);
      checks++; if (d[11:0] !== ys[k]) begin errors++; $display("FAIL div2_y[%0d]: got %h exp %h", k, d, ys[k]); end
    end
  endtask

  initial begin
    bus1.address = '0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
    bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    test_reset();
    test_auto();
    test_manual();
    test_back_to_back();
    test_w1c();
    test_clkdiv2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
